vpm_msg_monitor: RTL and testbench

Synthesizable, parametrised error/warning aggregator for vpm-instrumented designs. It collects per-cycle error and warning pulses from NCHAN assertion channels and keeps saturating totals. It holds off checking for a programmable arming window after reset and raises a stop request, acknowledged by a handshake, when configurable limits are reached. It sits at the top of the testbench or SoC debug wrapper as the hardware-side replacement for the behavioural error-count module.

---
 rtl/vpm_msg_pkg.sv | 32 +++
 rtl/vpm_sat_popcnt.sv | 30 +++
 rtl/vpm_msg_monitor.sv | 178 +++++++++++++++++
 tb/tb_vpm_msg_monitor.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpm_msg_pkg.sv
// Shared types and helpers for the vpm message monitor.
package vpm_msg_pkg;

    typedef enum logic [1:0] {
        ARMING   = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2,
        HALTED   = 2'd3
    } state_t;

    // Width of the intermediate used by the saturating adder; totals must be narrower.
    localparam int unsigned SAT_W = 64;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int unsigned chan_w(input int unsigned nchan);
        return (nchan <= 1) ? 1 : $clog2(nchan);
    endfunction

    // Add incr to total, clamping at the all-ones value of a width-bit counter.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] total,
        input logic [SAT_W-1:0] incr,
        input int unsigned      width
    );
        logic [SAT_W-1:0] max_val;
        logic [SAT_W-1:0] sum;
        max_val = (SAT_W'(1) << width) - SAT_W'(1);
        sum     = total + incr;
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage

// File: rtl/vpm_sat_popcnt.sv
// Counts the set bits of a pulse vector and adds them to a saturating total.
module vpm_sat_popcnt
    import vpm_msg_pkg::*;
#(
    parameter int unsigned NCHAN = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic [NCHAN-1:0] pulse,
    input  logic [CNT_W-1:0] total,
    output logic [CNT_W-1:0] sum_c
);

    localparam int unsigned PC_W = $clog2(NCHAN + 1);

    logic [PC_W-1:0] pop;

    // Population count of the pulse vector.
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(NCHAN); i++) begin
            pop = pop + PC_W'(pulse[i]);
        end
    end

    // Saturating accumulation onto the current total.
    always_comb begin
        sum_c = CNT_W'(sat_add(SAT_W'(total), SAT_W'(pop), CNT_W));
    end

endmodule

// File: rtl/vpm_msg_monitor.sv
// Error/warning aggregator: arming window, saturating totals, limit-driven stop handshake.
module vpm_msg_monitor
    import vpm_msg_pkg::*;
#(
    parameter int unsigned NCHAN        = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ERR_LIMIT    = 1,
    parameter int unsigned WARN_LIMIT   = 0,
    parameter int unsigned EXIT_ON_WARN = 0,
    parameter int unsigned ARM_DELAY    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCHAN-1:0]          err_pulse,
    input  logic [NCHAN-1:0]          warn_pulse,
    input  logic                      clear,
    input  logic                      stop_ack,
    output logic [CNT_W-1:0]          errors,
    output logic [CNT_W-1:0]          warnings,
    output logic                      message_on,
    output logic                      stop_req,
    output logic                      warn_notice,
    output logic [chan_w(NCHAN)-1:0]  first_chan,
    output logic                      first_is_err,
    output logic                      first_valid
);

    localparam int unsigned FC_W  = chan_w(NCHAN);
    localparam int unsigned ARM_W = (ARM_DELAY < 2) ? 1 : $clog2(ARM_DELAY + 1);

    state_t           state;
    state_t           state_next;
    logic [ARM_W-1:0] arm_cnt;
    logic [ARM_W-1:0] arm_next;
    logic [CNT_W-1:0] err_sum_c;
    logic [CNT_W-1:0] warn_sum_c;
    logic             stop_hit_c;
    logic             warn_hit_c;
    logic             count_en_c;
    logic             clr_en_c;
    logic [NCHAN-1:0] sel_c;
    logic [FC_W-1:0]  low_chan_c;
    logic             message_on_next;
    logic             stop_req_next;

    vpm_sat_popcnt #(.NCHAN(NCHAN), .CNT_W(CNT_W)) u_err_cnt (
        .pulse (err_pulse),
        .total (errors),
        .sum_c (err_sum_c)
    );

    vpm_sat_popcnt #(.NCHAN(NCHAN), .CNT_W(CNT_W)) u_warn_cnt (
        .pulse (warn_pulse),
        .total (warnings),
        .sum_c (warn_sum_c)
    );

    // Limit checks on the would-be totals of this cycle.
    always_comb begin
        stop_hit_c = ((ERR_LIMIT != 0) && (SAT_W'(err_sum_c) >= SAT_W'(ERR_LIMIT))) ||
                     ((EXIT_ON_WARN != 0) && (WARN_LIMIT != 0) &&
                      (SAT_W'(warn_sum_c) >= SAT_W'(WARN_LIMIT)));
        warn_hit_c = (EXIT_ON_WARN == 0) && (WARN_LIMIT != 0) &&
                     (SAT_W'(warn_sum_c) >= SAT_W'(WARN_LIMIT));
        count_en_c = (state == RUN) && !clear;
        clr_en_c   = clear && (state != ARMING);
    end

    // Lowest active channel, errors taking priority over warnings.
    always_comb begin
        sel_c      = (|err_pulse) ? err_pulse : warn_pulse;
        low_chan_c = '0;
        for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
            if (sel_c[i]) begin
                low_chan_c = FC_W'(i);
            end
        end
    end

    // State and arming counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARMING;
            arm_cnt <= ARM_W'(ARM_DELAY);
        end else begin
            state   <= state_next;
            arm_cnt <= arm_next;
        end
    end

    // Next-state logic; the arming window ends on the edge the counter lands on zero.
    always_comb begin
        state_next = state;
        arm_next   = arm_cnt;
        case (state)
            ARMING: begin
                arm_next = (arm_cnt == '0) ? '0 : arm_cnt - ARM_W'(1);
                if (arm_cnt <= ARM_W'(1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = RUN;
                end else if (stop_hit_c) begin
                    state_next = STOPPING;
                end
            end
            STOPPING: begin
                if (clear) begin
                    state_next = RUN;
                end else if (stop_ack) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (clear) begin
                    state_next = RUN;
                end
            end
            default: state_next = ARMING;
        endcase
    end

    // Output decode from the next state so the flags line up with the state register.
    always_comb begin
        message_on_next = (state_next == RUN);
        stop_req_next   = (state_next == STOPPING);
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            message_on <= 1'b0;
            stop_req   <= 1'b0;
        end else begin
            message_on <= message_on_next;
            stop_req   <= stop_req_next;
        end
    end

    // Totals and sticky warning notice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errors      <= '0;
            warnings    <= '0;
            warn_notice <= 1'b0;
        end else if (clr_en_c) begin
            errors      <= '0;
            warnings    <= '0;
            warn_notice <= 1'b0;
        end else if (count_en_c) begin
            errors   <= err_sum_c;
            warnings <= warn_sum_c;
            if (warn_hit_c) begin
                warn_notice <= 1'b1;
            end
        end
    end

    // First counted event capture, held until reset or clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_valid  <= 1'b0;
            first_is_err <= 1'b0;
            first_chan   <= '0;
        end else if (clr_en_c) begin
            first_valid  <= 1'b0;
            first_is_err <= 1'b0;
            first_chan   <= '0;
        end else if (count_en_c && !first_valid && ((|err_pulse) || (|warn_pulse))) begin
            first_valid  <= 1'b1;
            first_is_err <= |err_pulse;
            first_chan   <= low_chan_c;
        end
    end

endmodule

// File: tb/tb_vpm_msg_monitor.sv
// Bench for vpm_msg_monitor: two configurations driven in lockstep against a behavioural model.
module tb_vpm_msg_monitor;

    localparam int M_ARM  = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_HALT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] err;
    logic [3:0] warn;
    logic       clear;
    logic       ack;

    logic [15:0] e0, w0;
    logic [3:0]  e1, w1;
    logic        mo0, sr0, wn0, fie0, fv0;
    logic        mo1, sr1, wn1, fie1, fv1;
    logic [1:0]  fc0, fc1;

    vpm_msg_monitor #(
        .NCHAN(4), .CNT_W(16), .ERR_LIMIT(3), .WARN_LIMIT(2), .EXIT_ON_WARN(0), .ARM_DELAY(8)
    ) u0 (
        .clk(clk), .reset(reset), .err_pulse(err), .warn_pulse(warn), .clear(clear),
        .stop_ack(ack), .errors(e0), .warnings(w0), .message_on(mo0), .stop_req(sr0),
        .warn_notice(wn0), .first_chan(fc0), .first_is_err(fie0), .first_valid(fv0)
    );

    vpm_msg_monitor #(
        .NCHAN(4), .CNT_W(4), .ERR_LIMIT(0), .WARN_LIMIT(2), .EXIT_ON_WARN(1), .ARM_DELAY(0)
    ) u1 (
        .clk(clk), .reset(reset), .err_pulse(err), .warn_pulse(warn), .clear(clear),
        .stop_ack(ack), .errors(e1), .warnings(w1), .message_on(mo1), .stop_req(sr1),
        .warn_notice(wn1), .first_chan(fc1), .first_is_err(fie1), .first_valid(fv1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model configuration, one entry per instance.
    int cfg_elim[2] = '{3, 0};
    int cfg_wlim[2] = '{2, 2};
    int cfg_exit[2] = '{0, 1};
    int cfg_arm[2]  = '{8, 0};
    int cfg_max[2]  = '{65535, 15};
    int sat_exp[5]  = '{4, 8, 12, 15, 15};

    // Model state.
    int st[2], arm_left[2], etot[2], wtot[2], fch[2];
    bit notice[2], fv[2], fie[2];

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            st[k] = M_ARM; arm_left[k] = cfg_arm[k];
            etot[k] = 0; wtot[k] = 0; fch[k] = 0;
            notice[k] = 0; fv[k] = 0; fie[k] = 0;
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One clock edge of the reference behaviour, using the inputs present before the edge.
    task automatic mdl_edge(input int k);
        int ne, nw;
        if (st[k] == M_ARM) begin
            if (arm_left[k] > 0) arm_left[k]--;
            if (arm_left[k] == 0) st[k] = M_RUN;
        end else if (clear) begin
            etot[k] = 0; wtot[k] = 0; notice[k] = 0; fv[k] = 0; fie[k] = 0; fch[k] = 0;
            st[k] = M_RUN;
        end else if (st[k] == M_RUN) begin
            ne = $countones(err);
            nw = $countones(warn);
            if (!fv[k] && (ne + nw) > 0) begin
                fv[k] = 1; fie[k] = (ne > 0);
                fch[k] = lowest((ne > 0) ? err : warn);
            end
            etot[k] = (etot[k] + ne > cfg_max[k]) ? cfg_max[k] : etot[k] + ne;
            wtot[k] = (wtot[k] + nw > cfg_max[k]) ? cfg_max[k] : wtot[k] + nw;
            if ((cfg_elim[k] != 0 && etot[k] >= cfg_elim[k]) ||
                (cfg_exit[k] != 0 && cfg_wlim[k] != 0 && wtot[k] >= cfg_wlim[k]))
                st[k] = M_STOP;
            if (cfg_exit[k] == 0 && cfg_wlim[k] != 0 && wtot[k] >= cfg_wlim[k])
                notice[k] = 1;
        end else if (st[k] == M_STOP && ack) begin
            st[k] = M_HALT;
        end
    endtask

    function automatic logic [38:0] exp_vec(input int k);
        return {16'(etot[k]), 16'(wtot[k]), st[k] == M_RUN, st[k] == M_STOP,
                notice[k], 2'(fch[k]), fie[k], fv[k]};
    endfunction

    function automatic logic [38:0] obs_vec(input int k);
        if (k == 0) return {e0, w0, mo0, sr0, wn0, fc0, fie0, fv0};
        return {12'h0, e1, 12'h0, w1, mo1, sr1, wn1, fc1, fie1, fv1};
    endfunction

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        mdl_edge(0);
        mdl_edge(1);
        #1;
    endtask

    task automatic idle_inputs();
        err = '0; warn = '0; clear = 0; ack = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_vec(k) !== 39'h0) begin
                n_bad++;
                $display("FAIL reset_state u%0d: got %h expected %h", k, obs_vec(k), 39'h0);
            end
        end
        reset = 0;
    endtask

    task automatic test_arming();
        for (int c = 1; c <= 8; c++) begin
            err = 4'b0001;
            step();
            n_cmp++;
            if (e0 !== 16'd0 || mo0 !== (c == 8)) begin
                n_bad++;
                $display("FAIL arming c%0d: got errors=%0d message_on=%b expected errors=0 message_on=%b",
                         c, e0, mo0, c == 8);
            end
            n_cmp++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL arming_u1 c%0d: got %h expected %h", c, obs_vec(1), exp_vec(1));
            end
        end
        idle_inputs();
        clear = 1;
        step();
        clear = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL arm_clear u%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_err_limit();
        err = 4'b1011;
        step();
        err = '0;
        n_cmp++;
        if (e0 !== 16'd3 || sr0 !== 1'b1 || fc0 !== 2'd0 || fie0 !== 1'b1 || fv0 !== 1'b1) begin
            n_bad++;
            $display("FAIL err_limit: got e=%0d sr=%b fc=%0d fie=%b fv=%b expected e=3 sr=1 fc=0 fie=1 fv=1",
                     e0, sr0, fc0, fie0, fv0);
        end
        n_cmp++;
        if (e1 !== 4'd3 || sr1 !== 1'b0) begin
            n_bad++;
            $display("FAIL err_nolimit: got e=%0d sr=%b expected e=3 sr=0", e1, sr1);
        end
        ack = 1;
        step();
        ack = 0;
        n_cmp++;
        if (sr0 !== 1'b0 || mo0 !== 1'b0 || mo1 !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_ack: got sr0=%b mo0=%b mo1=%b expected 0 0 1", sr0, mo0, mo1);
        end
        err = 4'b0001;
        step();
        err = '0;
        n_cmp++;
        if (e0 !== 16'd3 || e1 !== 4'd4) begin
            n_bad++;
            $display("FAIL halted_frozen: got e0=%0d e1=%0d expected 3 4", e0, e1);
        end
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 5; c++) begin
            err = 4'b1111;
            step();
            n_cmp++;
            if (e1 !== 4'(sat_exp[c]) || sr1 !== 1'b0) begin
                n_bad++;
                $display("FAIL saturation c%0d: got e=%0d sr=%b expected e=%0d sr=0",
                         c, e1, sr1, sat_exp[c]);
            end
            n_cmp++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL sat_u0 c%0d: got %h expected %h", c, obs_vec(0), exp_vec(0));
            end
        end
        idle_inputs();
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic test_warn();
        warn = 4'b0100;
        step();
        n_cmp++;
        if (sr1 !== 1'b0 || w1 !== 4'd1) begin
            n_bad++;
            $display("FAIL warn_first: got w1=%0d sr1=%b expected 1 0", w1, sr1);
        end
        warn = 4'b0010;
        step();
        warn = '0;
        n_cmp++;
        if (w0 !== 16'd2 || wn0 !== 1'b1 || sr0 !== 1'b0 || fc0 !== 2'd2 || fie0 !== 1'b0) begin
            n_bad++;
            $display("FAIL warn_notice: got w=%0d wn=%b sr=%b fc=%0d fie=%b expected 2 1 0 2 0",
                     w0, wn0, sr0, fc0, fie0);
        end
        n_cmp++;
        if (w1 !== 4'd2 || sr1 !== 1'b1 || wn1 !== 1'b0) begin
            n_bad++;
            $display("FAIL warn_exit: got w=%0d sr=%b wn=%b expected 2 1 0", w1, sr1, wn1);
        end
        err = 4'b0001;
        clear = 1;
        step();
        idle_inputs();
        n_cmp++;
        if (e0 !== 16'd0 || e1 !== 4'd0 || mo0 !== 1'b1 || mo1 !== 1'b1 ||
            fv0 !== 1'b0 || fv1 !== 1'b0 || wn0 !== 1'b0 || sr1 !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_wins: got e0=%0d e1=%0d mo=%b%b fv=%b%b wn0=%b sr1=%b expected 0 0 11 00 0 0",
                     e0, e1, mo0, mo1, fv0, fv1, wn0, sr1);
        end
    endtask

    task automatic test_reset_in_stopping();
        err = 4'b0111;
        step();
        err = '0;
        n_cmp++;
        if (sr0 !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_stop: got sr0=%b expected 1", sr0);
        end
        reset = 1;
        mdl_reset();
        #1;
        n_cmp++;
        if (sr0 !== 1'b0 || e0 !== 16'd0 || e1 !== 4'd0 || mo0 !== 1'b0 || fv0 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got sr0=%b e0=%0d e1=%0d mo0=%b fv0=%b expected all 0",
                     sr0, e0, e1, mo0, fv0);
        end
        @(posedge clk);
        #1;
        reset = 0;
        for (int c = 1; c <= 8; c++) begin
            err  = 4'($urandom_range(1, 15));
            warn = 4'($urandom_range(0, 15));
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_bad++;
                    $display("FAIL rearm u%0d c%0d: got %h expected %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            err   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            warn  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            clear = ($urandom_range(0, 15) == 0);
            ack   = ($urandom_range(0, 3) == 0);
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_bad++;
                    $display("FAIL random u%0d c%0d: got %h expected %h", k, c, obs_vec(k), exp_vec(k));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        mdl_reset();
        test_reset();
        test_arming();
        test_err_limit();
        test_saturation();
        test_warn();
        test_reset_in_stopping();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
